// File: rtl/ibuf_pkg.sv
// Shared state encoding and default sizing for the instruction-buffer issue controller.
package ibuf_pkg;

    localparam int IBUF_DEPTH   = 16;
    localparam int IBUF_FETCH_W = 4;
    localparam int IBUF_ISSUE_W = 4;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ibuf_state_e;

endpackage

// File: rtl/ibuf_min3.sv
// Three-input unsigned minimum; shared with decode-side arbitration.
module ibuf_min3 #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_min
);

    logic [W-1:0] w_ab;

    always_comb begin
        w_ab  = (i_a < i_b) ? i_a : i_b;
        o_min = (w_ab < i_c) ? w_ab : i_c;
    end

endmodule

// File: rtl/ibuf_issue_ctrl.sv
// Occupancy/flow controller for the 4-in/4-out instruction buffer: write/read counts,
// fetch backpressure, issue-valid mask and flush/redirect sequencing.
module ibuf_issue_ctrl
    import ibuf_pkg::*;
#(
    parameter  int DEPTH   = IBUF_DEPTH,
    parameter  int FETCH_W = IBUF_FETCH_W,
    parameter  int ISSUE_W = IBUF_ISSUE_W,
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [CNT_W-1:0]   fetch_cnt,
    output logic               fetch_ready,
    input  logic [CNT_W-1:0]   dec_ready_cnt,
    input  logic               flush,
    input  logic               redirect_done,
    output logic [CNT_W-1:0]   buf_wen,
    output logic [CNT_W-1:0]   buf_ren,
    output logic               buf_clear,
    output logic [ISSUE_W-1:0] issue_valid,
    output logic [OCC_W-1:0]   occupancy,
    output logic               empty,
    output logic               full,
    output logic               proto_err
);

    ibuf_state_e          r_state;
    ibuf_state_e          w_state_next;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_proto_err;

    logic [OCC_W:0]       w_room;
    logic                 w_room_ok;
    logic [CNT_W-1:0]     w_wcnt;
    logic [CNT_W-1:0]     w_occ_cnt;
    logic [CNT_W-1:0]     w_ren_min;
    logic [OCC_W:0]       w_occ_sum;
    logic [OCC_W-1:0]     w_occ_next;
    logic                 w_set_err;

    function automatic logic [CNT_W-1:0] clamp_fetch(input logic [CNT_W-1:0] cnt);
        return (cnt > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : cnt;
    endfunction

    // Occupancy narrowed to count width; anything beyond ISSUE_W cannot be popped anyway.
    function automatic logic [CNT_W-1:0] sat_occ_cnt(input logic [OCC_W-1:0] occ);
        return (occ > OCC_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : occ[CNT_W-1:0];
    endfunction

    function automatic logic [OCC_W-1:0] sat_occ(input logic [OCC_W:0] sum);
        return (sum > (OCC_W+1)'(DEPTH)) ? OCC_W'(DEPTH) : sum[OCC_W-1:0];
    endfunction

    assign w_room    = (OCC_W+1)'(DEPTH) - {1'b0, r_occ};
    assign w_room_ok = (w_room >= (OCC_W+1)'(FETCH_W));
    assign w_wcnt    = clamp_fetch(fetch_cnt);
    assign w_occ_cnt = sat_occ_cnt(r_occ);

    ibuf_min3 #(
        .W (CNT_W)
    ) u_ren_min (
        .i_a   (w_occ_cnt),
        .i_b   (dec_ready_cnt),
        .i_c   (CNT_W'(ISSUE_W)),
        .o_min (w_ren_min)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:  w_state_next = ST_RUN;
            ST_RUN:   if (flush) w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (flush) begin
                    w_state_next = ST_DRAIN;
                end else if (redirect_done) begin
                    w_state_next = ST_RUN;
                end
            end
            default:  w_state_next = ST_INIT;
        endcase
    end

    // Output logic: zero-latency FIFO control from registered state plus inputs
    always_comb begin
        fetch_ready = 1'b0;
        buf_wen     = '0;
        buf_ren     = '0;
        buf_clear   = 1'b0;
        w_set_err   = 1'b0;
        if (reset) begin
            buf_clear = 1'b1;
        end else begin
            case (r_state)
                ST_INIT: buf_clear = 1'b1;
                ST_RUN: begin
                    fetch_ready = w_room_ok;
                    if (flush) begin
                        buf_clear = 1'b1;
                    end else begin
                        buf_wen   = (fetch_valid && w_room_ok) ? w_wcnt : '0;
                        buf_ren   = w_ren_min;
                        w_set_err = fetch_valid && (!w_room_ok || (fetch_cnt > CNT_W'(FETCH_W)));
                    end
                end
                ST_DRAIN: buf_clear = flush;
                default:  buf_clear = 1'b1;
            endcase
        end
    end

    always_comb begin
        issue_valid = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            issue_valid[i] = (CNT_W'(i) < buf_ren);
        end
    end

    assign w_occ_sum  = {1'b0, r_occ} + (OCC_W+1)'(buf_wen) - (OCC_W+1)'(buf_ren);
    assign w_occ_next = sat_occ(w_occ_sum);

    always_ff @(posedge clk) begin
        if (reset || buf_clear) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_set_err) begin
            r_proto_err <= 1'b1;
        end
    end

    assign occupancy = r_occ;
    assign proto_err = r_proto_err;
    assign empty     = (r_occ == '0);
    assign full      = (r_occ == OCC_W'(DEPTH));

endmodule

// File: tb/tb_ibuf_issue_ctrl.sv
// Directed bench for ibuf_issue_ctrl with hand-computed expected values.
module tb_ibuf_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_valid;
    logic [2:0] fetch_cnt;
    logic       fetch_ready;
    logic [2:0] dec_ready_cnt;
    logic       flush;
    logic       redirect_done;
    logic [2:0] buf_wen;
    logic [2:0] buf_ren;
    logic       buf_clear;
    logic [3:0] issue_valid;
    logic [4:0] occupancy;
    logic       empty;
    logic       full;
    logic       proto_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ibuf_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_cnt     (fetch_cnt),
        .fetch_ready   (fetch_ready),
        .dec_ready_cnt (dec_ready_cnt),
        .flush         (flush),
        .redirect_done (redirect_done),
        .buf_wen       (buf_wen),
        .buf_ren       (buf_ren),
        .buf_clear     (buf_clear),
        .issue_valid   (issue_valid),
        .occupancy     (occupancy),
        .empty         (empty),
        .full          (full),
        .proto_err     (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; registered outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [2:0] fc, input logic [2:0] dr,
                         input logic fl, input logic rd);
        fetch_valid   = fv;
        fetch_cnt     = fc;
        dec_ready_cnt = dr;
        flush         = fl;
        redirect_done = rd;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 3'd4, 3'd4, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_clear", buf_clear, 1);
        chk("rst_ready", fetch_ready, 0);
        chk("rst_wen", buf_wen, 0);
        chk("rst_ren", buf_ren, 0);
        chk("rst_iv", issue_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_err", proto_err, 0);

        reset = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("init_clear", buf_clear, 1);
        chk("init_ready", fetch_ready, 0);
        tick();
        chk("run_clear", buf_clear, 0);
        chk("run_ready", fetch_ready, 1);
        chk("run_empty", empty, 1);
        chk("run_occ", occupancy, 0);

        // Zero-count bundle is legal
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("cnt0_wen", buf_wen, 0);
        tick();
        chk("cnt0_err", proto_err, 0);
        chk("cnt0_occ", occupancy, 0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
            chk("fill_wen", buf_wen, 4);
            chk("fill_ren", buf_ren, 0);
            tick();
            fetch_valid = 1'b0;
            #1;
            chk("fill_occ", occupancy, 4 * (i + 1));
            chk("fill_ready", fetch_ready, (i < 3) ? 1 : 0);
        end
        chk("fill_full", full, 1);
        chk("fill_err", proto_err, 0);

        // Drain 16 -> 12 -> 8 -> 4 -> 2
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
            chk("drn_ren", buf_ren, 4);
            chk("drn_iv", issue_valid, 4'b1111);
            tick();
            chk("drn_occ", occupancy, 12 - 4 * i);
        end
        drive(1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
        chk("drn2_ren", buf_ren, 2);
        tick();
        chk("drn2_occ", occupancy, 2);

        // Mixed: no same-cycle bypass
        drive(1'b1, 3'd3, 3'd4, 1'b0, 1'b0);
        chk("mix_ren", buf_ren, 2);
        chk("mix_iv", issue_valid, 4'b0011);
        chk("mix_wen", buf_wen, 3);
        tick();
        chk("mix_occ", occupancy, 3);

        // Build to 9 then flush
        drive(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        tick();
        chk("pre_fl_occ", occupancy, 9);
        drive(1'b1, 3'd4, 3'd4, 1'b1, 1'b0);
        chk("fl_wen", buf_wen, 0);
        chk("fl_ren", buf_ren, 0);
        chk("fl_iv", issue_valid, 0);
        chk("fl_clear", buf_clear, 1);
        tick();
        drive(1'b1, 3'd4, 3'd4, 1'b0, 1'b0);
        chk("drain_occ", occupancy, 0);
        chk("drain_ready", fetch_ready, 0);
        chk("drain_wen", buf_wen, 0);
        chk("drain_clear", buf_clear, 0);
        tick();
        chk("drain_occ2", occupancy, 0);
        chk("drain_err", proto_err, 0);
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("redir_ready", fetch_ready, 1);

        // Flush and redirect together in DRAIN
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
        chk("flrd_clear", buf_clear, 1);
        tick();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("flrd_ready", fetch_ready, 0);
        chk("flrd_noclr", buf_clear, 0);
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("flrd_run", fetch_ready, 1);

        // Violation at occupancy 14 with oversized count
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        tick();
        chk("v_occ", occupancy, 14);
        drive(1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
        chk("v_ready", fetch_ready, 0);
        chk("v_wen", buf_wen, 0);
        tick();
        chk("v_err", proto_err, 1);
        chk("v_occ2", occupancy, 14);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
            tick();
        end
        chk("v_empty", empty, 1);
        chk("v_sticky", proto_err, 1);

        reset = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("v_rst_err", proto_err, 0);
        tick();

        // Oversized count with room: clamped to FETCH_W and flagged
        drive(1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
        chk("clamp_wen", buf_wen, 4);
        tick();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("clamp_occ", occupancy, 4);
        chk("clamp_err", proto_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
